stepper_move_sequencer: RTL and testbench

Converts a two-axis move command (step counts plus directions, as produced by `scara_controller`'s DegToSteps stage) into time-synchronized STEP/DIR pulse trains for the two joint stepper drivers. Uses Bresenham interpolation so both joints start and finish together, with programmable step period and direction-setup time. Sits between the kinematics controller and the driver pins. It accepts one move at a time over a valid/ready handshake.

---
 rtl/stepper_move_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_stepper_move_sequencer.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_move_sequencer.sv
// Two-axis STEP/DIR pulse generator: Bresenham-interpolated moves with direction
// setup time, fixed pulse width, programmable step period and abort.
module stepper_move_sequencer #(
    parameter int STEP_W           = 32,
    parameter int PERIOD_W         = 16,
    parameter int PULSE_CYCLES     = 50,
    parameter int DIR_SETUP_CYCLES = 100
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [STEP_W-1:0]   cmd_steps1,
    input  logic [STEP_W-1:0]   cmd_steps2,
    input  logic                cmd_dir1,
    input  logic                cmd_dir2,
    input  logic [PERIOD_W-1:0] step_period,
    input  logic                abort,
    output logic                step1,
    output logic                step2,
    output logic                dir1,
    output logic                dir2,
    output logic                busy,
    output logic                done,
    output logic                aborted
);

    localparam int CNT_W = 32;
    localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2 * PULSE_CYCLES);
    localparam logic [CNT_W-1:0] PULSE_LEN  = CNT_W'(PULSE_CYCLES);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(DIR_SETUP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_GAP,
        S_FINISH
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]         period_q, period_d;
    logic [STEP_W-1:0]        major_q, major_d;
    logic [STEP_W-1:0]        minor_q, minor_d;
    logic [STEP_W-1:0]        remain_q, remain_d;
    logic signed [STEP_W+1:0] err_q, err_d;
    logic                     j2_major_q, j2_major_d;
    logic                     step1_q, step1_d;
    logic                     step2_q, step2_d;
    logic                     dir1_q, dir1_d;
    logic                     dir2_q, dir2_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     aborted_q, aborted_d;
    logic                     ready_q, ready_d;

    logic [CNT_W-1:0]         period_ext;
    logic                     new_j2_major;
    logic [STEP_W-1:0]        new_major;
    logic [STEP_W-1:0]        new_minor;
    logic signed [STEP_W+1:0] err_sub;
    logic                     minor_hit;
    logic                     start_pulse;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        period_d     = period_q;
        major_d      = major_q;
        minor_d      = minor_q;
        remain_d     = remain_q;
        err_d        = err_q;
        j2_major_d   = j2_major_q;
        step1_d      = step1_q;
        step2_d      = step2_q;
        dir1_d       = dir1_q;
        dir2_d       = dir2_q;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        start_pulse  = 1'b0;

        period_ext   = CNT_W'(step_period);
        new_j2_major = cmd_steps2 > cmd_steps1;
        new_major    = new_j2_major ? cmd_steps2 : cmd_steps1;
        new_minor    = new_j2_major ? cmd_steps1 : cmd_steps2;
        // Bresenham step decision for the pulse about to start
        err_sub      = err_q - $signed({2'b00, minor_q});
        minor_hit    = err_sub[STEP_W+1];

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    major_d    = new_major;
                    minor_d    = new_minor;
                    remain_d   = new_major;
                    j2_major_d = new_j2_major;
                    err_d      = $signed({2'b00, new_major >> 1});
                    period_d   = (period_ext > MIN_PERIOD) ? period_ext : MIN_PERIOD;
                    if (new_major == '0) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        dir1_d  = cmd_dir1;
                        dir2_d  = cmd_dir2;
                        cnt_d   = SETUP_LOAD;
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                if (abort) begin
                    state_d   = S_FINISH;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (cnt_q == '0) begin
                    start_pulse = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1;
                end
            end
            S_PULSE: begin
                if (abort) begin
                    state_d   = S_FINISH;
                    step1_d   = 1'b0;
                    step2_d   = 1'b0;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (cnt_q == '0) begin
                    step1_d = 1'b0;
                    step2_d = 1'b0;
                    cnt_d   = period_q - PULSE_LEN - 1;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q - 1;
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d   = S_FINISH;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (cnt_q == '0) begin
                    remain_d = remain_q - 1;
                    if (remain_q == STEP_W'(1)) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        start_pulse = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The major axis always steps; the minor axis only when the error wraps
        if (start_pulse) begin
            state_d = S_PULSE;
            cnt_d   = PULSE_LOAD;
            err_d   = minor_hit ? (err_sub + $signed({2'b00, major_q})) : err_sub;
            step1_d = j2_major_q ? minor_hit : 1'b1;
            step2_d = j2_major_q ? 1'b1 : minor_hit;
        end

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            period_q   <= '0;
            major_q    <= '0;
            minor_q    <= '0;
            remain_q   <= '0;
            err_q      <= '0;
            j2_major_q <= 1'b0;
            step1_q    <= 1'b0;
            step2_q    <= 1'b0;
            dir1_q     <= 1'b0;
            dir2_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            major_q    <= major_d;
            minor_q    <= minor_d;
            remain_q   <= remain_d;
            err_q      <= err_d;
            j2_major_q <= j2_major_d;
            step1_q    <= step1_d;
            step2_q    <= step2_d;
            dir1_q     <= dir1_d;
            dir2_q     <= dir2_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
            ready_q    <= ready_d;
        end
    end

    assign cmd_ready = ready_q;
    assign step1     = step1_q;
    assign step2     = step2_q;
    assign dir1      = dir1_q;
    assign dir2      = dir2_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_stepper_move_sequencer.sv
// Bench for stepper_move_sequencer: directed scenarios plus random moves checked
// against an arithmetic Bresenham model of expected STEP rise edges.
module tb_stepper_move_sequencer;

    localparam int STEP_W   = 32;
    localparam int PERIOD_W = 16;
    localparam int PC       = 50;
    localparam int DS       = 100;

    logic                clk         = 1'b0;
    logic                reset       = 1'b1;
    logic                cmd_valid   = 1'b0;
    logic [STEP_W-1:0]   cmd_steps1  = '0;
    logic [STEP_W-1:0]   cmd_steps2  = '0;
    logic                cmd_dir1    = 1'b0;
    logic                cmd_dir2    = 1'b0;
    logic [PERIOD_W-1:0] step_period = '0;
    logic                abort       = 1'b0;
    logic                cmd_ready, step1, step2, dir1, dir2, busy, done, aborted;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   acc_q[$];
    int   r1_q[$];
    int   r2_q[$];
    int   f1_q[$];
    int   f2_q[$];
    int   done_q[$];
    int   abt_q[$];
    int   busy_cycles = 0;
    logic pv = 1'b0, pr = 1'b0, ps1 = 1'b0, ps2 = 1'b0;
    logic md1 = 1'b0, md2 = 1'b0;

    stepper_move_sequencer #(
        .STEP_W(STEP_W), .PERIOD_W(PERIOD_W),
        .PULSE_CYCLES(PC), .DIR_SETUP_CYCLES(DS)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_steps1(cmd_steps1), .cmd_steps2(cmd_steps2),
        .cmd_dir1(cmd_dir1), .cmd_dir2(cmd_dir2), .step_period(step_period),
        .abort(abort), .step1(step1), .step2(step2), .dir1(dir1), .dir2(dir2),
        .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log indexed by edge number: values seen at a negedge follow edge 'cyc'
    always @(negedge clk) begin
        if (pv && pr) acc_q.push_back(cyc);
        if (step1 && !ps1) r1_q.push_back(cyc);
        if (!step1 && ps1) f1_q.push_back(cyc);
        if (step2 && !ps2) r2_q.push_back(cyc);
        if (!step2 && ps2) f2_q.push_back(cyc);
        if (done) begin
            done_q.push_back(cyc);
            abt_q.push_back(int'(aborted));
        end
        if (busy) busy_cycles++;
        pv  = cmd_valid;
        pr  = cmd_ready;
        ps1 = step1;
        ps2 = step2;
    end

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    // Minor-axis pulses issued after k major steps of a Bresenham line
    function automatic int hits(input int k, input int maj, input int mino);
        int x;
        x = k * mino - maj / 2;
        if (x <= 0) return 0;
        return (x + maj - 1) / maj;
    endfunction

    task automatic clear_log();
        acc_q.delete(); r1_q.delete(); r2_q.delete(); f1_q.delete(); f2_q.delete();
        done_q.delete(); abt_q.delete();
        busy_cycles = 0;
    endtask

    task automatic start_move(input int s1, input int s2, input logic d1, input logic d2,
                              input int per, output int n);
        cmd_steps1  = STEP_W'(s1);
        cmd_steps2  = STEP_W'(s2);
        cmd_dir1    = d1;
        cmd_dir2    = d2;
        step_period = PERIOD_W'(per);
        cmd_valid   = 1'b1;
        n = -1;
        for (int i = 0; i < 3000 && n < 0; i++) begin
            if (cmd_ready === 1'b1) begin
                @(posedge clk); #1;
                n = cyc;
            end else begin
                @(posedge clk); #1;
            end
        end
        cmd_valid = 1'b0;
        checks++;
        if (n < 0) begin
            errors++;
            $display("[TB] FAIL accept_timeout: got no accept, expected one within 3000 cycles");
        end else if (s1 != 0 || s2 != 0) begin
            md1 = d1;
            md2 = d2;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({step1, step2, dir1, dir2, busy, done, aborted, cmd_ready} !== 8'b0000_0001) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected 00000001",
                     {step1, step2, dir1, dir2, busy, done, aborted, cmd_ready});
        end
        reset = 1'b0;
        md1 = 1'b0; md2 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int n;
        int e1[4] = '{100, 300, 500, 700};
        int e2[2] = '{300, 700};
        clear_log();
        start_move(4, 2, 1'b1, 1'b0, 200, n);
        checks++;
        if ({dir1, dir2} !== 2'b10) begin
            errors++; $display("[TB] FAIL basic_dir: got %b expected 10", {dir1, dir2});
        end
        repeat (905) @(posedge clk);
        #1;
        checks++;
        if (r1_q.size() != 4) begin
            errors++; $display("[TB] FAIL basic_step1_count: got %0d expected 4", r1_q.size());
        end
        foreach (e1[i]) begin
            checks++;
            if (qget(r1_q, i) != n + e1[i]) begin
                errors++; $display("[TB] FAIL basic_step1_rise%0d: got %0d expected %0d", i, qget(r1_q, i), n + e1[i]);
            end
            checks++;
            if (qget(f1_q, i) != n + e1[i] + PC) begin
                errors++; $display("[TB] FAIL basic_step1_fall%0d: got %0d expected %0d", i, qget(f1_q, i), n + e1[i] + PC);
            end
        end
        checks++;
        if (r2_q.size() != 2) begin
            errors++; $display("[TB] FAIL basic_step2_count: got %0d expected 2", r2_q.size());
        end
        foreach (e2[i]) begin
            checks++;
            if (qget(r2_q, i) != n + e2[i]) begin
                errors++; $display("[TB] FAIL basic_step2_rise%0d: got %0d expected %0d", i, qget(r2_q, i), n + e2[i]);
            end
        end
        checks++;
        if (done_q.size() != 1 || qget(done_q, 0) != n + 900 || qget(abt_q, 0) != 0) begin
            errors++; $display("[TB] FAIL basic_done: got edge %0d aborted %0d expected edge %0d aborted 0",
                               qget(done_q, 0), qget(abt_q, 0), n + 900);
        end
    endtask

    task automatic test_zero_move();
        int   n;
        logic o1, o2;
        o1 = md1; o2 = md2;
        clear_log();
        start_move(0, 0, ~o1, ~o2, 200, n);
        checks++;
        if ({done, busy, cmd_ready, dir1, dir2} !== {3'b110, o1, o2}) begin
            errors++; $display("[TB] FAIL zero_state: got %b expected %b", {done, busy, cmd_ready, dir1, dir2}, {3'b110, o1, o2});
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (r1_q.size() != 0 || r2_q.size() != 0) begin
            errors++; $display("[TB] FAIL zero_pulses: got %0d/%0d expected 0/0", r1_q.size(), r2_q.size());
        end
        checks++;
        if (qget(done_q, 0) != n || busy_cycles != 1) begin
            errors++; $display("[TB] FAIL zero_done: got edge %0d busy %0d expected edge %0d busy 1", qget(done_q, 0), busy_cycles, n);
        end
        checks++;
        if ({dir1, dir2, cmd_ready} !== {o1, o2, 1'b1}) begin
            errors++; $display("[TB] FAIL zero_dir_hold: got %b expected %b", {dir1, dir2, cmd_ready}, {o1, o2, 1'b1});
        end
    endtask

    task automatic test_j2_major();
        int n;
        int e2[3] = '{100, 220, 340};
        clear_log();
        start_move(0, 3, 1'b0, 1'b1, 120, n);
        repeat (470) @(posedge clk);
        #1;
        checks++;
        if (r1_q.size() != 0 || r2_q.size() != 3 || dir2 !== 1'b1) begin
            errors++; $display("[TB] FAIL j2_counts: got step1 %0d step2 %0d dir2 %b expected 0 3 1", r1_q.size(), r2_q.size(), dir2);
        end
        foreach (e2[i]) begin
            checks++;
            if (qget(r2_q, i) != n + e2[i]) begin
                errors++; $display("[TB] FAIL j2_rise%0d: got %0d expected %0d", i, qget(r2_q, i), n + e2[i]);
            end
        end
        checks++;
        if (qget(done_q, 0) != n + 460) begin
            errors++; $display("[TB] FAIL j2_done: got %0d expected %0d", qget(done_q, 0), n + 460);
        end
    endtask

    task automatic test_period_clamp();
        int n;
        clear_log();
        start_move(2, 0, 1'b1, 1'b1, 10, n);
        repeat (310) @(posedge clk);
        #1;
        checks++;
        if (r1_q.size() != 2 || qget(r1_q, 0) != n + 100 || qget(r1_q, 1) != n + 200) begin
            errors++; $display("[TB] FAIL clamp_rises: got %0d %0d expected %0d %0d", qget(r1_q, 0), qget(r1_q, 1), n + 100, n + 200);
        end
        checks++;
        if (qget(f1_q, 0) != n + 150 || qget(f1_q, 1) != n + 250) begin
            errors++; $display("[TB] FAIL clamp_falls: got %0d %0d expected %0d %0d", qget(f1_q, 0), qget(f1_q, 1), n + 150, n + 250);
        end
        checks++;
        if (qget(done_q, 0) != n + 300 || r2_q.size() != 0) begin
            errors++; $display("[TB] FAIL clamp_done: got %0d expected %0d", qget(done_q, 0), n + 300);
        end
    endtask

    task automatic test_abort();
        int n, m;
        clear_log();
        start_move(10, 0, 1'b1, 1'b0, 200, n);
        repeat (120) @(posedge clk);
        #1;
        checks++;
        if (step1 !== 1'b1) begin
            errors++; $display("[TB] FAIL abort_pre_step: got %b expected 1", step1);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if ({step1, done, aborted, busy, dir1} !== 5'b01111) begin
            errors++; $display("[TB] FAIL abort_finish: got %b expected 01111", {step1, done, aborted, busy, dir1});
        end
        @(posedge clk); #1;
        checks++;
        if ({cmd_ready, done, aborted, busy} !== 4'b1000) begin
            errors++; $display("[TB] FAIL abort_idle: got %b expected 1000", {cmd_ready, done, aborted, busy});
        end
        checks++;
        if (r1_q.size() != 1 || qget(done_q, 0) != n + 121) begin
            errors++; $display("[TB] FAIL abort_log: got rises %0d done %0d expected 1 %0d", r1_q.size(), qget(done_q, 0), n + 121);
        end
        clear_log();
        start_move(1, 1, 1'b0, 1'b0, 100, m);
        repeat (210) @(posedge clk);
        #1;
        checks++;
        if (qget(r1_q, 0) != m + 100 || qget(r2_q, 0) != m + 100 || qget(done_q, 0) != m + 200 || qget(abt_q, 0) != 0) begin
            errors++; $display("[TB] FAIL abort_next_move: got %0d %0d %0d %0d expected %0d %0d %0d 0",
                               qget(r1_q, 0), qget(r2_q, 0), qget(done_q, 0), qget(abt_q, 0), m + 100, m + 100, m + 200);
        end
    endtask

    task automatic test_reset_mid_move();
        int n;
        start_move(3, 3, 1'b1, 1'b1, 200, n);
        repeat (149) @(posedge clk);
        #1;
        checks++;
        if ({busy, dir1, dir2} !== 3'b111) begin
            errors++; $display("[TB] FAIL mid_pre_reset: got %b expected 111", {busy, dir1, dir2});
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({step1, step2, dir1, dir2, busy, done, aborted, cmd_ready} !== 8'b0000_0001) begin
            errors++; $display("[TB] FAIL mid_reset_outputs: got %b expected 00000001",
                               {step1, step2, dir1, dir2, busy, done, aborted, cmd_ready});
        end
        reset = 1'b0;
        md1 = 1'b0; md2 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        clear_log();
        cmd_steps1 = STEP_W'(1); cmd_steps2 = '0;
        cmd_dir1 = 1'b0; cmd_dir2 = 1'b0;
        step_period = PERIOD_W'(100);
        cmd_valid = 1'b1;
        for (int i = 0; i < 1000 && acc_q.size() < 2; i++) begin
            @(negedge clk); #1;
        end
        cmd_valid = 1'b0;
        md1 = 1'b0; md2 = 1'b0;
        repeat (230) @(posedge clk);
        #1;
        checks++;
        if (acc_q.size() != 2 || done_q.size() != 2) begin
            errors++; $display("[TB] FAIL b2b_counts: got accepts %0d dones %0d expected 2 2", acc_q.size(), done_q.size());
        end
        checks++;
        if (qget(done_q, 0) != qget(acc_q, 0) + 200) begin
            errors++; $display("[TB] FAIL b2b_first_done: got %0d expected %0d", qget(done_q, 0), qget(acc_q, 0) + 200);
        end
        // done cycle, then one idle cycle with cmd_ready high, then the accepting edge
        checks++;
        if (qget(acc_q, 1) != qget(done_q, 0) + 2) begin
            errors++; $display("[TB] FAIL b2b_second_accept: got %0d expected %0d", qget(acc_q, 1), qget(done_q, 0) + 2);
        end
        checks++;
        if (qget(done_q, 1) != qget(acc_q, 1) + 200) begin
            errors++; $display("[TB] FAIL b2b_second_done: got %0d expected %0d", qget(done_q, 1), qget(acc_q, 1) + 200);
        end
    endtask

    task automatic test_random_moves();
        for (int it = 0; it < 8; it++) begin
            int   s1, s2, per, p, n, maj, mino, exp_done;
            logic d1, d2, j2;
            int   emaj[$];
            int   emin[$];
            int   e1[$];
            int   e2[$];
            s1  = $urandom_range(0, 5);
            s2  = $urandom_range(0, 5);
            per = $urandom_range(0, 260);
            d1  = 1'($urandom_range(0, 1));
            d2  = 1'($urandom_range(0, 1));
            p    = (per > 2 * PC) ? per : 2 * PC;
            j2   = s2 > s1;
            maj  = j2 ? s2 : s1;
            mino = j2 ? s1 : s2;
            clear_log();
            start_move(s1, s2, d1, d2, per, n);
            for (int k = 1; k <= maj; k++) begin
                emaj.push_back(n + DS + (k - 1) * p);
                if (hits(k, maj, mino) > hits(k - 1, maj, mino)) emin.push_back(n + DS + (k - 1) * p);
            end
            e1 = j2 ? emin : emaj;
            e2 = j2 ? emaj : emin;
            exp_done = (maj == 0) ? n : n + DS + maj * p;
            repeat ((maj == 0) ? 5 : DS + maj * p + 5) @(posedge clk);
            #1;
            checks++;
            if (r1_q.size() != e1.size() || r2_q.size() != e2.size()) begin
                errors++; $display("[TB] FAIL rand%0d_counts: got %0d/%0d expected %0d/%0d (s1=%0d s2=%0d P=%0d)",
                                   it, r1_q.size(), r2_q.size(), e1.size(), e2.size(), s1, s2, p);
            end
            foreach (e1[i]) begin
                checks++;
                if (qget(r1_q, i) != e1[i]) begin
                    errors++; $display("[TB] FAIL rand%0d_step1_rise%0d: got %0d expected %0d", it, i, qget(r1_q, i), e1[i]);
                end
            end
            foreach (e2[i]) begin
                checks++;
                if (qget(r2_q, i) != e2[i]) begin
                    errors++; $display("[TB] FAIL rand%0d_step2_rise%0d: got %0d expected %0d", it, i, qget(r2_q, i), e2[i]);
                end
            end
            checks++;
            if (done_q.size() != 1 || qget(done_q, 0) != exp_done || qget(abt_q, 0) != 0) begin
                errors++; $display("[TB] FAIL rand%0d_done: got %0d expected %0d", it, qget(done_q, 0), exp_done);
            end
            checks++;
            if ({dir1, dir2} !== {md1, md2}) begin
                errors++; $display("[TB] FAIL rand%0d_dir: got %b expected %b", it, {dir1, dir2}, {md1, md2});
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_move();
        test_j2_major();
        test_period_clamp();
        test_abort();
        test_reset_mid_move();
        test_back_to_back();
        test_random_moves();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
